// File: rtl/lc3_ctrl_pkg.sv
// Shared encodings for the LC-3 control sequencer: FSM states, opcodes and datapath mux codes.
package lc3_ctrl_pkg;

  localparam int unsigned STATE_BITS = 5;

  typedef enum logic [STATE_BITS-1:0] {
    S_IDLE   = 5'd0,
    S_FETCH1 = 5'd1,
    S_FETCH2 = 5'd2,
    S_FETCH3 = 5'd3,
    S_DECODE = 5'd4,
    S_ALU_EX = 5'd5,
    S_LD1    = 5'd6,
    S_LD2    = 5'd7,
    S_LD3    = 5'd8,
    S_ST1    = 5'd9,
    S_ST2    = 5'd10,
    S_ST3    = 5'd11,
    S_BR     = 5'd12,
    S_JMP    = 5'd13,
    S_HALT   = 5'd14
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;

  localparam logic [1:0] PCMUX_INC  = 2'b00;
  localparam logic [1:0] PCMUX_ADDR = 2'b01;
  localparam logic [1:0] PCMUX_BUS  = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  function automatic logic [1:0] aluk_of(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALUK_ADD;
      OP_AND:  return ALUK_AND;
      OP_NOT:  return ALUK_NOT;
      default: return ALUK_PASS;
    endcase
  endfunction

endpackage

// File: rtl/lc3_ctrl_fsm_br_eval.sv
// Branch-enable evaluation: BR is taken when any requested condition matches a set flag.
module lc3_br_eval (
  input  logic [2:0] cond_i,
  input  logic       n_i,
  input  logic       z_i,
  input  logic       p_i,
  output logic       ben_o
);

  assign ben_o = |(cond_i & {n_i, z_i, p_i});

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// Multi-cycle LC-3 control sequencer (ADD/AND/NOT/LD/ST/BR/JMP).
// Optional memory-access watchdog enabled by defining LC3_CTRL_MEM_TIMEOUT_EN.
module lc3_ctrl_fsm
  import lc3_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W     = 5,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Run,
  input  logic [15:0]        IR,
  input  logic               N,
  input  logic               Z,
  input  logic               P,
  input  logic               MEM_R,
  output logic               LD_PC,
  output logic               LD_MAR,
  output logic               LD_MDR,
  output logic               LD_IR,
  output logic               LD_REG,
  output logic               LD_CC,
  output logic               GATE_PC,
  output logic               GATE_MDR,
  output logic               GATE_ALU,
  output logic               GATE_MARMUX,
  output logic               MEM_EN,
  output logic               R_W,
  output logic [1:0]         PCMUX,
  output logic               ADDR1MUX,
  output logic [1:0]         ADDR2MUX,
  output logic [1:0]         ALUK,
  output logic               o_Halt,
  output logic [STATE_W-1:0] o_State
);

  state_e state_q, state_d;
  state_e boundary;
  logic   ben;
  logic   unused_ir;

  lc3_br_eval u_br_eval (
    .cond_i (IR[11:9]),
    .n_i    (N),
    .z_i    (Z),
    .p_i    (P),
    .ben_o  (ben)
  );

  assign unused_ir = ^IR[8:0];
  assign o_State   = STATE_W'(state_q);
  // Entry to FETCH1 is the only point where a stop request takes effect.
  assign boundary  = i_Run ? S_FETCH1 : S_IDLE;

`ifdef LC3_CTRL_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_wait;

  assign mem_wait = !MEM_R &&
                    (state_q == S_FETCH2 || state_q == S_LD2 || state_q == S_ST3);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  localparam int unsigned unused_mem_timeout = MEM_TIMEOUT;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    LD_PC       = 1'b0;
    LD_MAR      = 1'b0;
    LD_MDR      = 1'b0;
    LD_IR       = 1'b0;
    LD_REG      = 1'b0;
    LD_CC       = 1'b0;
    GATE_PC     = 1'b0;
    GATE_MDR    = 1'b0;
    GATE_ALU    = 1'b0;
    GATE_MARMUX = 1'b0;
    MEM_EN      = 1'b0;
    R_W         = 1'b0;
    PCMUX       = PCMUX_INC;
    ADDR1MUX    = 1'b0;
    ADDR2MUX    = ADDR2_ZERO;
    ALUK        = ALUK_ADD;
    o_Halt      = 1'b0;

    case (state_q)
      S_IDLE: if (i_Run) state_d = S_FETCH1;
      S_FETCH1: begin
        GATE_PC = 1'b1;
        LD_MAR  = 1'b1;
        LD_PC   = 1'b1;
        PCMUX   = PCMUX_INC;
        state_d = S_FETCH2;
      end
      S_FETCH2: begin
        MEM_EN = 1'b1;
        LD_MDR = MEM_R;
        if (MEM_R) state_d = S_FETCH3;
      end
      S_FETCH3: begin
        GATE_MDR = 1'b1;
        LD_IR    = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        case (IR[15:12])
          OP_ADD, OP_AND, OP_NOT: state_d = S_ALU_EX;
          OP_LD:                  state_d = S_LD1;
          OP_ST:                  state_d = S_ST1;
          OP_BR:                  state_d = S_BR;
          OP_JMP:                 state_d = S_JMP;
          default:                state_d = S_HALT;
        endcase
      end
      S_ALU_EX: begin
        GATE_ALU = 1'b1;
        LD_REG   = 1'b1;
        LD_CC    = 1'b1;
        ALUK     = aluk_of(IR[15:12]);
        state_d  = boundary;
      end
      S_LD1, S_ST1: begin
        ADDR1MUX    = 1'b0;
        ADDR2MUX    = ADDR2_OFF9;
        GATE_MARMUX = 1'b1;
        LD_MAR      = 1'b1;
        state_d     = (state_q == S_LD1) ? S_LD2 : S_ST2;
      end
      S_LD2: begin
        MEM_EN = 1'b1;
        LD_MDR = MEM_R;
        if (MEM_R) state_d = S_LD3;
      end
      S_LD3: begin
        GATE_MDR = 1'b1;
        LD_REG   = 1'b1;
        LD_CC    = 1'b1;
        state_d  = boundary;
      end
      S_ST2: begin
        ALUK     = ALUK_PASS;
        GATE_ALU = 1'b1;
        LD_MDR   = 1'b1;
        state_d  = S_ST3;
      end
      S_ST3: begin
        MEM_EN = 1'b1;
        R_W    = 1'b1;
        if (MEM_R) state_d = boundary;
      end
      S_BR: begin
        LD_PC    = ben;
        PCMUX    = PCMUX_ADDR;
        ADDR1MUX = 1'b0;
        ADDR2MUX = ADDR2_OFF9;
        state_d  = boundary;
      end
      S_JMP: begin
        ADDR1MUX = 1'b1;
        ADDR2MUX = ADDR2_ZERO;
        PCMUX    = PCMUX_ADDR;
        LD_PC    = 1'b1;
        state_d  = boundary;
      end
      S_HALT: begin
        o_Halt = 1'b1;
        if (!i_Run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef LC3_CTRL_MEM_TIMEOUT_EN
    // The final waiting cycle still drives MEM_EN; the access is abandoned by entering HALT.
    cnt_d = '0;
    if (mem_wait) begin
      if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) state_d = S_HALT;
      else                                 cnt_d   = cnt_q + 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Directed scoreboard bench for lc3_ctrl_fsm; expected outputs come from a table of per-state strobes.
module tb_lc3_ctrl_fsm;
  import lc3_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] ir;
  logic        n, z, p;
  logic        mem_r;
  logic        ld_pc, ld_mar, ld_mdr, ld_ir, ld_reg, ld_cc;
  logic        g_pc, g_mdr, g_alu, g_marmux;
  logic        mem_en, r_w;
  logic [1:0]  pcmux, addr2mux, aluk;
  logic        addr1mux;
  logic        halt;
  logic [4:0]  st;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [24:0] exp_q[$];
  string       tag_q[$];

  lc3_ctrl_fsm #(.STATE_W(5), .MEM_TIMEOUT(255)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Run(run), .IR(ir), .N(n), .Z(z), .P(p),
    .MEM_R(mem_r), .LD_PC(ld_pc), .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir),
    .LD_REG(ld_reg), .LD_CC(ld_cc), .GATE_PC(g_pc), .GATE_MDR(g_mdr), .GATE_ALU(g_alu),
    .GATE_MARMUX(g_marmux), .MEM_EN(mem_en), .R_W(r_w), .PCMUX(pcmux),
    .ADDR1MUX(addr1mux), .ADDR2MUX(addr2mux), .ALUK(aluk), .o_Halt(halt), .o_State(st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] exp_vec(input state_e s);
    logic lpc, lmar, lmdr, lir, lreg, lcc, gpc, gmdr, galu, gmm, men, rw, a1, h;
    logic [1:0] pm, a2, ak;
    logic [3:0] op;
    {lpc, lmar, lmdr, lir, lreg, lcc, gpc, gmdr, galu, gmm, men, rw, a1, h} = '0;
    pm = 2'b00; a2 = 2'b00; ak = 2'b00;
    op = ir[15:12];
    case (s)
      S_FETCH1: begin gpc = 1'b1; lmar = 1'b1; lpc = 1'b1; end
      S_FETCH2, S_LD2: begin men = 1'b1; lmdr = mem_r; end
      S_FETCH3: begin gmdr = 1'b1; lir = 1'b1; end
      S_ALU_EX: begin
        galu = 1'b1; lreg = 1'b1; lcc = 1'b1;
        ak = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
      end
      S_LD1, S_ST1: begin gmm = 1'b1; lmar = 1'b1; a2 = 2'b10; end
      S_LD3: begin gmdr = 1'b1; lreg = 1'b1; lcc = 1'b1; end
      S_ST2: begin ak = 2'b11; galu = 1'b1; lmdr = 1'b1; end
      S_ST3: begin men = 1'b1; rw = 1'b1; end
      S_BR: begin
        lpc = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
        pm = 2'b01; a2 = 2'b10;
      end
      S_JMP: begin a1 = 1'b1; pm = 2'b01; lpc = 1'b1; end
      S_HALT: h = 1'b1;
      default: ;
    endcase
    return {lpc, lmar, lmdr, lir, lreg, lcc, gpc, gmdr, galu, gmm, men, rw,
            pm, a1, a2, ak, h, 5'(s)};
  endfunction

  task automatic chk(input state_e s, input string tag);
    logic [24:0] obs, expv;
    string       t;
    exp_q.push_back(exp_vec(s));
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {ld_pc, ld_mar, ld_mdr, ld_ir, ld_reg, ld_cc, g_pc, g_mdr, g_alu, g_marmux,
           mem_en, r_w, pcmux, addr1mux, addr2mux, aluk, halt, st};
    expv = exp_q.pop_front();
    t    = tag_q.pop_front();
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, obs, expv);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string t, input int unsigned stall);
    mem_r = 1'b1;
    chk(S_FETCH1, {t, "_f1"});
    mem_r = 1'b0;
    for (int unsigned i = 0; i < stall; i++) chk(S_FETCH2, {t, "_f2wait"});
    mem_r = 1'b1;
    chk(S_FETCH2, {t, "_f2"});
    chk(S_FETCH3, {t, "_f3"});
    chk(S_DECODE, {t, "_dec"});
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; ir = '0; n = 1'b0; z = 1'b0; p = 1'b0; mem_r = 1'b0;
    @(posedge clk);
    #1;
    chk(S_IDLE, "rst_hold");
    rst_n = 1'b1;
    chk(S_IDLE, "rst_release");

    ir = 16'h1042;
    fetch("add", 0);
    chk(S_ALU_EX, "add_ex");
    ir = 16'h5042;
    fetch("and", 2);
    chk(S_ALU_EX, "and_ex");
    ir = 16'h967F;
    fetch("not", 0);
    chk(S_ALU_EX, "not_ex");

    ir = 16'h0A05; n = 1'b0; z = 1'b1; p = 1'b0;
    fetch("brnp_z", 0);
    chk(S_BR, "brnp_z_nottaken");
    n = 1'b1; z = 1'b0;
    fetch("brnp_n", 0);
    chk(S_BR, "brnp_n_taken");
    ir = 16'h0005; n = 1'b1; z = 1'b1; p = 1'b1;
    fetch("br000", 0);
    chk(S_BR, "br000_never");
    ir = 16'h0E05; n = 1'b0; z = 1'b0; p = 1'b1;
    fetch("brnzp", 0);
    chk(S_BR, "brnzp_p_taken");

    ir = 16'hC1C0;
    fetch("jmp", 0);
    chk(S_JMP, "jmp");

    ir = 16'h2005;
    fetch("ld", 0);
    chk(S_LD1, "ld1");
    mem_r = 1'b0;
    for (int unsigned i = 0; i < 3; i++) chk(S_LD2, "ld2_wait");
    mem_r = 1'b1;
    chk(S_LD2, "ld2_ready");
    chk(S_LD3, "ld3");

    ir = 16'h3005;
    fetch("st", 0);
    chk(S_ST1, "st1");
    run = 1'b0;
    chk(S_ST2, "st2_run0");
    mem_r = 1'b0;
    chk(S_ST3, "st3_wait");
    mem_r = 1'b1;
    chk(S_ST3, "st3_done");
    chk(S_IDLE, "st_to_idle");
    chk(S_IDLE, "idle_hold");

    run = 1'b1;
    ir  = 16'hF025;
    chk(S_IDLE, "idle_go");
    fetch("trap", 0);
    chk(S_HALT, "halt");
    chk(S_HALT, "halt_hold");
    run = 1'b0;
    chk(S_HALT, "halt_run0");
    chk(S_IDLE, "halt_to_idle");

    run = 1'b1;
    ir  = 16'h1042;
    chk(S_IDLE, "idle_go2");
    chk(S_FETCH1, "pre_rst_f1");
    mem_r = 1'b0;
    chk(S_FETCH2, "pre_rst_f2");
    rst_n = 1'b0;
    #1;
    chk(S_IDLE, "rst_mid_access");
    rst_n = 1'b1;
    chk(S_IDLE, "rst2_release");
    chk(S_FETCH1, "to_f1");
    mem_r = 1'b0;
`ifdef LC3_CTRL_MEM_TIMEOUT_EN
    for (int unsigned i = 0; i < 255; i++) chk(S_FETCH2, "tmo_wait");
    chk(S_HALT, "tmo_halt");
`else
    for (int unsigned i = 0; i < 300; i++) chk(S_FETCH2, "wait_forever");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
